piso_serializer: RTL and testbench
==================================

# piso_serializer

Parallel-in/serial-out stage that accepts an (N+1)-bit word over a valid/ready handshake and emits it LSB-first, one bit per accepted serial beat. Each beat shifts the held word one place right with zero fill, using the team's one-bit logical-right-shift stage. The block sits directly downstream of the word producer. Its serial output feeds a single-bit link or consumer with backpressure.

## Interface
- N, default 7: MSB index of the data word. Word width is N+1. Legal range N ≥ 1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N+1  parallel word to serialize.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts a word this cycle.
- sdo  output  1  current serial bit.
- out_valid  output  1  sdo is valid.
- out_ready  input  1  consumer takes sdo this cycle.
- out_last  output  1  sdo is the final bit (bit N) of the current word.
- busy  output  1  a word is held (state SHIFT).

## Operation
- Handshake rules:
  - Input transfer: in_valid && in_ready at a clk edge.
  - Output beat: out_valid && out_ready at a clk edge.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On an input transfer: sreg ← in_data, cnt ← 0, go to SHIFT.
- State SHIFT:
  - out_valid=1, sdo=sreg[0], out_last=(cnt==N).
  - Beat with cnt<N: sreg ← {1'b0, sreg[N:1]} (logical right shift by one), cnt ← cnt+1.
  - Beat with cnt==N, in_valid=1: reload sreg ← in_data, cnt ← 0, stay in SHIFT (zero-bubble back-to-back).
  - Beat with cnt==N, in_valid=0: go to IDLE. sreg is left as is.
- in_ready = (state==IDLE) || (state==SHIFT && cnt==N && out_ready). It is combinational from state, cnt and out_ready. It never depends on in_valid.
- No beat (out_ready=0): sreg, cnt, sdo and out_last hold. in_valid is ignored unless in_ready=1.
- cnt width is $clog2(N+1). cnt never exceeds N, so there is no wrap.
- out_valid never drops mid-word once asserted. sdo is stable while out_valid=1 and out_ready=0.
- in_data is sampled only on an input transfer. Later changes have no effect.
- busy = (state==SHIFT).

## Timing
- Reset (asynchronous, rst_n low):
  - State IDLE, sreg=0, cnt=0.
  - Outputs: out_valid=0, sdo=0, out_last=0, busy=0, in_ready=1.
  - No transfer is registered while rst_n is low.
- Reset asserted mid-word aborts the word immediately, with no further beats. After rst_n rises the block is in IDLE.
- Latency: an input transfer at edge k gives bit0 on sdo with out_valid=1 after edge k, i.e. in cycle k+1.
- Throughput: with out_ready held at 1, one word takes N+1 cycles. Back-to-back words have no idle cycle.
- Simultaneous final beat and new input: both happen at the same edge. The next cycle shows the new word's bit0 with out_last=0.
- Only out_valid, sdo, out_last and busy leave the block as registered-derived outputs. in_ready is the only output with a combinational path from an input (out_ready).

## Structure
- Shared package piso_pkg:
  - typedef enum logic {IDLE, SHIFT} piso_state_t.
  - localparam function for the count width, cnt_w(N) = $clog2(N+1).
- Sub-module: the existing one-bit logical-right-shift stage, instantiated as the sreg next-value path.
  - Parameterised with N.
  - Its outputs b[0..N-2] take a[1..N-1]; b[N-1] and b[N] are undriven.
  - In piso_serializer, the shift path takes b[N-2:0] and wires bit N-1 to sreg[N] and bit N to 1'b0 locally, giving the full zero-filled right shift.
- All other logic stays in piso_serializer: the FSM, cnt, and the handshake logic.

## Test plan
- N=7, in_data=8'hA5 with one in_valid pulse, out_ready=1:
  - sdo = 1,0,1,0,0,1,0,1 over 8 consecutive cycles.
  - out_last=1 only on the 8th cycle. busy drops the cycle after.
- Backpressure: load 8'h81, toggle out_ready 1,0,0,1,…:
  - sdo holds during out_ready=0.
  - Exactly 8 beats: 1,0,0,0,0,0,0,1.
  - cnt never advances on stalled cycles.
- Back-to-back: 8'hA5 then 8'h3C, in_valid held high:
  - 16 contiguous beats with out_valid never dropping.
  - The second word starts 0,0,1,1.
  - in_ready=1 exactly on the two transfer cycles.
- Ignore while busy: pulse in_valid with 8'hFF at cnt=3 of 8'h00 (in_ready=0).
  - The stream stays eight 0s.
  - 8'hFF is not loaded unless in_valid is still high on the last beat.
- Reset mid-word: drop rst_n at cnt=4.
  - out_valid, sdo, busy and out_last go to 0 asynchronously, with in_ready=1.
  - After release, a fresh load of 8'h01 gives 1 followed by seven 0s.
- N=1 boundary: word 2'b10 gives sdo 0 then 1, with out_last on the 2nd beat.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// piso_pkg: shared types and helpers for the parallel-in/serial-out serializer.
//   piso_state_t : FSM states (IDLE waits for a word, SHIFT emits its bits)
//   cnt_w(n)     : width of the bit counter for a word whose MSB index is n
package piso_pkg;

    typedef enum logic {IDLE, SHIFT} piso_state_t;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// piso_serializer_if: word-in / bit-out handshake bundle of the serializer.
//   in_data, in_valid, in_ready : parallel word handshake (producer -> serializer)
//   sdo, out_valid, out_ready,
//   out_last                    : serial bit handshake (serializer -> consumer)
// Modports:
//   slave  : the serializer's view (consumes words, produces bits)
//   master : the environment's view (produces words, consumes bits)
interface piso_serializer_if #(
    parameter int N = 7
);

    logic [N:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       sdo;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output sdo,
        output out_valid,
        input  out_ready,
        output out_last
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  sdo,
        input  out_valid,
        output out_ready,
        input  out_last
    );

endinterface

// File: rtl/piso_serializer_lsr.sv
// lsr1_stage: one-bit logical-right-shift stage covering the interior bits of
// a word with MSB index N. Output bit i takes input bit i+1 for i = 0..N-2.
// The two top bits of the full shifted word (the old MSB moving down, and
// the zero fill) are supplied by the instantiating module.
//   a : input bits [N-1:1] of the word being shifted
//   b : shifted bits [N-2:0]
// Needs N >= 2; for smaller words the caller wires the shift directly.
module lsr1_stage #(
    parameter int N = 7
) (
    input  logic [N-1:1] a,
    output logic [N-2:0] b
);

    for (genvar i = 0; i <= N - 2; i++) begin : g_bit
        assign b[i] = a[i + 1];
    end

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: accepts an (N+1)-bit word over a valid/ready handshake and
// emits it LSB-first, one bit per accepted serial beat. The final beat of a
// word can coincide with accepting the next word, so back-to-back words
// stream with no idle cycle.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : word-in / bit-out handshake (slave side)
//   busy  : high while a word is held (state SHIFT)
module piso_serializer
    import piso_pkg::*;
#(
    parameter int N = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    piso_serializer_if.slave   bus,
    output logic               busy
);

    localparam int            CW       = cnt_w(N);
    localparam logic [CW-1:0] LAST_CNT = CW'(N);

    piso_state_t   state_q, state_d;
    logic [N:0]    sreg_q, sreg_d, sreg_shr;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_last;

    // Zero-filled right shift of the held word. The shared stage moves the
    // interior bits; the old MSB and the zero fill are wired here.
    if (N >= 2) begin : g_shr
        lsr1_stage #(.N(N)) u_lsr (
            .a (sreg_q[N-1:1]),
            .b (sreg_shr[N-2:0])
        );
        assign sreg_shr[N-1] = sreg_q[N];
        assign sreg_shr[N]   = 1'b0;
    end else begin : g_shr_min
        assign sreg_shr = {1'b0, sreg_q[1]};
    end

    // The bit on sdo is the word's MSB when the counter has reached N.
    assign at_last = (state_q == SHIFT) && (cnt_q == LAST_CNT);

    // Outputs. in_ready may only open in SHIFT on the final beat, which is
    // what lets the next word load in the same edge as the last bit leaves.
    assign bus.in_ready  = (state_q == IDLE) || (at_last && bus.out_ready);
    assign bus.out_valid = (state_q == SHIFT);
    assign bus.sdo       = (state_q == SHIFT) & sreg_q[0];
    assign bus.out_last  = at_last;
    assign busy          = (state_q == SHIFT);

    // Next-state logic. Nothing moves in SHIFT without a beat, so a stalled
    // consumer sees sdo and out_last frozen.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sreg_d  = bus.in_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.out_ready) begin
                    if (!at_last) begin
                        sreg_d = sreg_shr;
                        cnt_d  = cnt_q + CW'(1);
                    end else if (bus.in_valid) begin
                        sreg_d = bus.in_data;
                        cnt_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    // State register; reset drops any word in flight immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: self-checking bench for piso_serializer. Drives an N=7
// instance through a table of single-word vectors, directed multi-cycle
// sequences and a randomized run against a bit-queue reference model, plus
// an N=1 instance for the smallest legal word.
module tb_piso_serializer;
    import piso_pkg::*;

    logic clk;
    logic rst_n;
    logic busy7;
    logic busy1;

    int checks = 0;
    int errors = 0;

    piso_serializer_if #(.N(7)) bus7 ();
    piso_serializer_if #(.N(1)) bus1 ();

    piso_serializer #(.N(7)) dut7 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus7.slave),
        .busy  (busy7)
    );

    piso_serializer #(.N(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave),
        .busy  (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic       iv;
        logic [7:0] data;
        logic       ordy;
        logic       expRdy;
        logic       expValid;
        logic       expSdo;
        logic       expLast;
        logic       expBusy;
    } vec_t;

    vec_t vecs [9];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [7:0] d, input logic o);
        bus7.in_valid  = iv;
        bus7.in_data   = d;
        bus7.out_ready = o;
        #1;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference for the N=7 instance: the bits still owed to the consumer.
    bit refQ [$];

    initial begin
        logic [7:0] w;
        logic [15:0] stream;
        int beats;
        logic o;
        logic iv;
        logic [7:0] d;
        logic expRdy;

        rst_n = 1'b0;
        bus7.in_valid = 1'b0; bus7.in_data = '0; bus7.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;

        vecs[0] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state
        @(negedge clk);
        #1;
        checkOutput("rst_valid", bus7.out_valid, 1'b0);
        checkOutput("rst_sdo", bus7.sdo, 1'b0);
        checkOutput("rst_last", bus7.out_last, 1'b0);
        checkOutput("rst_busy", busy7, 1'b0);
        checkOutput("rst_rdy", bus7.in_ready, 1'b1);
        stepCycle();
        rst_n = 1'b1;
        stepCycle();

        // Single word 8'hA5, consumer always ready
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].iv, vecs[i].data, vecs[i].ordy);
            checkOutput($sformatf("a5_rdy[%0d]", i), bus7.in_ready, vecs[i].expRdy);
            stepCycle();
            checkOutput($sformatf("a5_valid[%0d]", i), bus7.out_valid, vecs[i].expValid);
            checkOutput($sformatf("a5_last[%0d]", i), bus7.out_last, vecs[i].expLast);
            checkOutput($sformatf("a5_busy[%0d]", i), busy7, vecs[i].expBusy);
            if (vecs[i].expValid)
                checkOutput($sformatf("a5_sdo[%0d]", i), bus7.sdo, vecs[i].expSdo);
        end

        // Backpressure with 8'h81, out_ready pattern 1,0,0,1,0,0,...
        w = 8'h81;
        applyStimulus(1'b1, w, 1'b0);
        checkOutput("bp_rdy_load", bus7.in_ready, 1'b1);
        stepCycle();
        beats = 0;
        for (int cyc = 0; cyc < 40 && beats < 8; cyc++) begin
            checkOutput("bp_valid", bus7.out_valid, 1'b1);
            checkOutput($sformatf("bp_sdo[%0d]", beats), bus7.sdo, w[beats]);
            checkOutput($sformatf("bp_last[%0d]", beats), bus7.out_last, (beats == 7));
            o = (cyc % 3 == 0);
            applyStimulus(1'b0, 8'h00, o);
            stepCycle();
            if (o) beats++;
        end
        checkOutput("bp_beats", beats, 8);
        checkOutput("bp_idle", bus7.out_valid, 1'b0);

        // Back-to-back 8'hA5 then 8'h3C with in_valid held high
        stream = 16'h3CA5;
        applyStimulus(1'b1, 8'hA5, 1'b1);
        checkOutput("b2b_rdy_first", bus7.in_ready, 1'b1);
        stepCycle();
        for (int j = 0; j < 16; j++) begin
            checkOutput($sformatf("b2b_valid[%0d]", j), bus7.out_valid, 1'b1);
            checkOutput($sformatf("b2b_sdo[%0d]", j), bus7.sdo, stream[j]);
            checkOutput($sformatf("b2b_last[%0d]", j), bus7.out_last, (j == 7 || j == 15));
            applyStimulus((j <= 7), 8'h3C, 1'b1);
            checkOutput($sformatf("b2b_rdy[%0d]", j), bus7.in_ready, (j == 7 || j == 15));
            stepCycle();
        end
        checkOutput("b2b_idle", bus7.out_valid, 1'b0);

        // in_valid pulse with 8'hFF while 8'h00 is mid-word is ignored
        applyStimulus(1'b1, 8'h00, 1'b1);
        stepCycle();
        for (int j = 0; j < 8; j++) begin
            checkOutput($sformatf("ign_valid[%0d]", j), bus7.out_valid, 1'b1);
            checkOutput($sformatf("ign_sdo[%0d]", j), bus7.sdo, 1'b0);
            applyStimulus((j == 3), 8'hFF, 1'b1);
            if (j == 3) checkOutput("ign_rdy", bus7.in_ready, 1'b0);
            stepCycle();
        end
        checkOutput("ign_idle", bus7.out_valid, 1'b0);
        checkOutput("ign_busy", busy7, 1'b0);

        // Reset asserted at cnt=4 of 8'hFF
        applyStimulus(1'b1, 8'hFF, 1'b1);
        stepCycle();
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            stepCycle();
        end
        checkOutput("mrst_pre_sdo", bus7.sdo, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("mrst_valid", bus7.out_valid, 1'b0);
        checkOutput("mrst_sdo", bus7.sdo, 1'b0);
        checkOutput("mrst_busy", busy7, 1'b0);
        checkOutput("mrst_last", bus7.out_last, 1'b0);
        checkOutput("mrst_rdy", bus7.in_ready, 1'b1);
        applyStimulus(1'b1, 8'hFF, 1'b1);
        stepCycle();
        checkOutput("mrst_noload", bus7.out_valid, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        rst_n = 1'b1;
        stepCycle();
        checkOutput("mrst_after", bus7.out_valid, 1'b0);
        w = 8'h01;
        applyStimulus(1'b1, w, 1'b1);
        stepCycle();
        for (int j = 0; j < 8; j++) begin
            checkOutput($sformatf("mrst_valid[%0d]", j), bus7.out_valid, 1'b1);
            checkOutput($sformatf("mrst_sdo[%0d]", j), bus7.sdo, w[j]);
            applyStimulus(1'b0, 8'h00, 1'b1);
            stepCycle();
        end
        checkOutput("mrst_end", bus7.out_valid, 1'b0);

        // N=1 boundary: word 2'b10
        bus1.in_valid = 1'b1; bus1.in_data = 2'b10; bus1.out_ready = 1'b1;
        #1;
        checkOutput("n1_rdy", bus1.in_ready, 1'b1);
        stepCycle();
        bus1.in_valid = 1'b0;
        checkOutput("n1_valid0", bus1.out_valid, 1'b1);
        checkOutput("n1_sdo0", bus1.sdo, 1'b0);
        checkOutput("n1_last0", bus1.out_last, 1'b0);
        stepCycle();
        checkOutput("n1_valid1", bus1.out_valid, 1'b1);
        checkOutput("n1_sdo1", bus1.sdo, 1'b1);
        checkOutput("n1_last1", bus1.out_last, 1'b1);
        stepCycle();
        checkOutput("n1_idle", bus1.out_valid, 1'b0);
        checkOutput("n1_busy", busy1, 1'b0);

        // Randomized traffic against the bit-queue model
        rst_n = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        stepCycle();
        rst_n = 1'b1;
        stepCycle();
        refQ.delete();
        for (int c = 0; c < 400; c++) begin
            iv = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            o  = ($urandom_range(0, 3) != 0);
            applyStimulus(iv, d, o);
            expRdy = (refQ.size() == 0) || (refQ.size() == 1 && o);
            checkOutput("rnd_rdy", bus7.in_ready, expRdy);
            if (refQ.size() > 0 && o) void'(refQ.pop_front());
            if (expRdy && iv)
                for (int b = 0; b < 8; b++) refQ.push_back(d[b]);
            stepCycle();
            checkOutput("rnd_valid", bus7.out_valid, (refQ.size() > 0));
            checkOutput("rnd_last", bus7.out_last, (refQ.size() == 1));
            checkOutput("rnd_busy", busy7, (refQ.size() > 0));
            if (refQ.size() > 0)
                checkOutput("rnd_sdo", bus7.sdo, refQ[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
